// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared cache geometry and fill FSM state encoding
package cache_pkg;

    localparam int BLOCK_WORDS   = 8;
    localparam int WORD_IDX_BITS = $clog2(BLOCK_WORDS);
    // Word index plus the byte-select bit of a 16-bit word.
    localparam int OFFSET_BITS   = WORD_IDX_BITS + 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } fill_state_e;

endpackage

// File: rtl/cache_fill_fsm.sv
// rtl/cache_fill_fsm.sv - cache-miss block fill controller for a 16-bit word memory
module cache_fill_fsm #(
    parameter int ADDR_WIDTH  = 16,
    parameter int BLOCK_WORDS = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           miss_detected,
    input  logic [ADDR_WIDTH-1:0]          miss_address,
    output logic                           fsm_busy,
    output logic                           mem_enable,
    output logic                           mem_wr,
    output logic [ADDR_WIDTH-1:0]          mem_addr,
    input  logic                           mem_data_valid,
    input  logic [15:0]                    mem_data_in,
    output logic                           cache_wr_en,
    output logic [$clog2(BLOCK_WORDS)-1:0] cache_wr_word,
    output logic [15:0]                    cache_wr_data,
    output logic                           tag_wr_en,
    output logic                           fill_done
);
    import cache_pkg::*;

    localparam int WORD_BITS = $clog2(BLOCK_WORDS);
    localparam logic [0:0] IDLE = ST_IDLE;
    localparam logic [0:0] FILL = ST_FILL;
    localparam logic [WORD_BITS:0]   ICNT_ALL    = (WORD_BITS + 1)'(BLOCK_WORDS);
    localparam logic [WORD_BITS-1:0] RCNT_LAST   = WORD_BITS'(BLOCK_WORDS - 1);
    localparam logic [ADDR_WIDTH-1:0] OFFSET_MASK = ADDR_WIDTH'((1 << (WORD_BITS + 1)) - 1);

    logic [0:0]            state;
    logic [WORD_BITS:0]    icnt;
    logic [WORD_BITS-1:0]  rcnt;
    logic [ADDR_WIDTH-1:0] base;

    logic in_fill;
    logic issuing;
    logic wr_hit;
    logic last_word;

    assign in_fill   = (state == FILL);
    assign issuing   = in_fill && (icnt < ICNT_ALL);
    assign wr_hit    = in_fill && mem_data_valid;
    assign last_word = wr_hit && (rcnt == RCNT_LAST);

    assign fsm_busy      = in_fill;
    assign mem_enable    = issuing;
    assign mem_wr        = 1'b0;
    // Base is block-aligned, so the word offset never carries out of the block.
    assign mem_addr      = issuing ? (base + ADDR_WIDTH'({icnt, 1'b0})) : '0;
    assign cache_wr_en   = wr_hit;
    assign cache_wr_word = wr_hit ? rcnt : '0;
    assign cache_wr_data = mem_data_in;
    assign tag_wr_en     = last_word;
    assign fill_done     = last_word;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            icnt  <= '0;
            rcnt  <= '0;
            base  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (miss_detected) begin
                        base  <= miss_address & ~OFFSET_MASK;
                        icnt  <= '0;
                        rcnt  <= '0;
                        state <= FILL;
                    end
                end
                FILL: begin
                    if (issuing) begin
                        icnt <= icnt + 1'b1;
                    end
                    if (wr_hit) begin
                        rcnt <= rcnt + 1'b1;
                    end
                    if (last_word) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/cache_fill_fsm.md
# cache_fill_fsm

Cache-miss fill controller: on a miss it acts as the requesting side of the byte-addressed, 16-bit-wide word memory. It issues one word-read per cycle for the whole cache block, collects the returned words in order, and writes each into the cache data array. It sits between the I/D cache control logic and the multi-cycle memory, and signals tag update and completion when the last word arrives.

## Interface
- `ADDR_WIDTH`, 16, byte-address width.
- `BLOCK_WORDS`, 8, 16-bit words per cache block; must be a power of two, ≥2.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `miss_detected`  in  1  cache miss pending; sampled only in IDLE.
- `miss_address`  in  ADDR_WIDTH  byte address of the missing access; sampled with `miss_detected`.
- `fsm_busy`  out  1  high in FILL.
- `mem_enable`  out  1  memory read request strobe.
- `mem_wr`  out  1  constant 0; reads only.
- `mem_addr`  out  ADDR_WIDTH  request byte address; bit 0 always 0.
- `mem_data_valid`  in  1  a returned word is present this cycle.
- `mem_data_in`  in  16  returned word.
- `cache_wr_en`  out  1  write `cache_wr_data` into word `cache_wr_word` of the block being filled.
- `cache_wr_word`  out  log2(BLOCK_WORDS)  word index within the block.
- `cache_wr_data`  out  16  equals `mem_data_in`.
- `tag_wr_en`  out  1  one-cycle pulse: write tag and set valid.
- `fill_done`  out  1  one-cycle pulse: fill complete.

## Operation
- **States:** IDLE and FILL.
- **Entering FILL:** in IDLE with `miss_detected`=1, the next edge does the following:
  - latches the block base: `miss_address` with its low log2(BLOCK_WORDS)+1 bits cleared;
  - clears the issue counter `icnt` and the receive counter `rcnt`;
  - moves to FILL.
- **Issue:** in FILL while `icnt` < BLOCK_WORDS:
  - `mem_enable`=1 and `mem_addr` = base + 2·`icnt`;
  - `icnt` increments every cycle; there is no backpressure;
  - once all words are issued, `mem_enable`=0.
- **Receive:** in FILL with `mem_data_valid`=1:
  - `cache_wr_en`=1, `cache_wr_word`=`rcnt`;
  - `rcnt` increments.
  - Returns are in request order. Issue and receive may overlap in the same cycle.
- **Completion:** in FILL with `mem_data_valid`=1 and `rcnt`=BLOCK_WORDS-1:
  - `tag_wr_en` and `fill_done` are asserted in that same cycle;
  - the next state is IDLE.
- **Inputs ignored:**
  - `mem_data_valid` in IDLE: no cache write.
  - `miss_detected` or `miss_address` changing during FILL: the fill completes for the latched base.
- **Back-to-back misses:** `miss_detected` still high in the first IDLE cycle after `fill_done` starts a new fill. The cache must drop it on `fill_done` if the miss is resolved.
- **Counter widths:**
  - `icnt` is log2(BLOCK_WORDS)+1 bits, so "all issued" is representable.
  - `rcnt` is log2(BLOCK_WORDS) bits.
  - Address addition wraps modulo 2^ADDR_WIDTH; it cannot carry out of the block because the base is aligned.

## Timing
- **Output decoding:**
  - `mem_enable`, `mem_addr` and `fsm_busy` decode from registered state.
  - `cache_wr_en`, `cache_wr_word`, `tag_wr_en` and `fill_done` are combinational on `mem_data_valid` and registered state.
  - `cache_wr_data` is a combinational pass-through of `mem_data_in`.
- **Requests:** the first request is in the cycle immediately after the edge that samples the miss. The following BLOCK_WORDS-1 requests are in consecutive cycles.
- **Fill length:** with memory latency L, where data is valid L cycles after its request cycle, the FILL duration is BLOCK_WORDS+L cycles.
- **Reset:**
  - rst=1 at an edge forces IDLE and clears counters and base, including mid-fill.
  - All outputs are 0 after that edge; the partial fill is abandoned with no `tag_wr_en`.
  - `mem_data_valid` is ignored for the cycles while rst is held.

## Structure
- Shared package `cache_pkg`:
  - state enum (IDLE, FILL);
  - `BLOCK_WORDS` and the derived offset-bit constant, used by the cache arrays and tag logic.
- No sub-module: the state register and two counters are inline. Target 120–200 lines.

## Test plan
- **Basic fill:** L=4, `miss_address`=0x1234, held.
  - Requests 0x1230, 0x1232, …, 0x123E in 8 consecutive cycles.
  - `cache_wr_word` 0..7 with data 0xA000..0xA007.
  - `tag_wr_en`/`fill_done` in the 12th FILL cycle; IDLE next.
- **Top of address space:** `miss_address`=0xFFFF → base 0xFFF0, last request 0xFFFE, no wrap into 0x0000.
- **Irregular returns:** valids gapped with 2 idle cycles between each word → 8 ordered writes, `fill_done` only on the 8th valid, `mem_enable` low after 8 requests.
- **Reset mid-fill:** rst after the 3rd write → outputs 0 next edge. A following miss at 0x0040 refills from word 0 with requests 0x0040..0x004E.
- **Inputs ignored:**
  - `mem_data_valid` pulsed in IDLE → no `cache_wr_en`.
  - `miss_address` changed to 0x8000 mid-fill → requests stay on the original block.
- **Back-to-back misses:** `miss_detected` held through `fill_done` → second fill starts the cycle after IDLE is entered; `fill_done` pulses exactly once per fill.
